// File: rtl/ram_scan_disp.sv
// Tick-paced RAM with manual/auto-scan registered read, hardware clear after reset and 7-seg output.
// Define RAM_SCAN_ADDR_DISP_EN to add hex_addr, showing the address of the word held in q.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zero one RAM location per clk; ticks and user inputs ignored
// ST_RUN   | on each tick: optional write, registered read, pointer update
module ram_scan_disp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic                                scan,
    output logic                                busy,
    output logic [DATA_WIDTH-1:0]               q,
    output logic [ADDR_WIDTH-1:0]               rd_ptr,
    output logic [7*((DATA_WIDTH+3)/4)-1:0]     hex
`ifdef RAM_SCAN_ADDR_DISP_EN
    ,
    output logic [7*((ADDR_WIDTH+3)/4)-1:0]     hex_addr
`endif
);

    localparam int DEPTH   = 2**ADDR_WIDTH;
    localparam int NUM_HEX = (DATA_WIDTH+3)/4;
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   tick;
    logic [ADDR_WIDTH-1:0]  clr_addr;
    logic                   clr_we;
    logic                   run_tick;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign tick = (tick_cnt == CNT_W'(TICK_DIV-1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        run_tick  = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr == ADDR_WIDTH'(DEPTH-1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                run_tick = tick;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst)         clr_addr <= '0;
        else if (clr_we) clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end

    // RAM has no reset of its own; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)              mem[clr_addr] <= '0;
            else if (run_tick && we) mem[wr_addr]  <= wr_data;
        end
    end

    // Read uses the pre-tick pointer and pre-write contents (read-old on collision).
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            rd_ptr <= '0;
        end else if (run_tick) begin
            q      <= mem[rd_ptr];
            rd_ptr <= scan ? rd_ptr + ADDR_WIDTH'(1) : rd_addr;
        end
    end

    logic [4*NUM_HEX-1:0] q_ext;
    assign q_ext = (4*NUM_HEX)'(q);

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        assign hex[7*i +: 7] = seg7(q_ext[4*i +: 4]);
    end

`ifdef RAM_SCAN_ADDR_DISP_EN
    localparam int NUM_HEX_A = (ADDR_WIDTH+3)/4;

    logic [ADDR_WIDTH-1:0]  addr_shown;
    logic [4*NUM_HEX_A-1:0] addr_ext;

    always_ff @(posedge clk) begin
        if (rst)           addr_shown <= '0;
        else if (run_tick) addr_shown <= rd_ptr;
    end

    assign addr_ext = (4*NUM_HEX_A)'(addr_shown);

    for (genvar j = 0; j < NUM_HEX_A; j++) begin : g_hex_addr
        assign hex_addr[7*j +: 7] = seg7(addr_ext[4*j +: 4]);
    end
`endif

endmodule

// File: tb/tb_ram_scan_disp.sv
// Bench for ram_scan_disp (DATA_WIDTH=8, ADDR_WIDTH=4, TICK_DIV=4): cycle-level model plus directed checks.
// Build with RAM_SCAN_ADDR_DISP_EN defined to also cover hex_addr.
module tb_ram_scan_disp;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int TDIV  = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          scan;
    logic          busy;
    logic [DW-1:0] q;
    logic [AW-1:0] rd_ptr;
    logic [13:0]   hex;
`ifdef RAM_SCAN_ADDR_DISP_EN
    logic [6:0]    hex_addr;
`endif

    ram_scan_disp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .scan(scan), .busy(busy), .q(q), .rd_ptr(rd_ptr),
        .hex(hex)
`ifdef RAM_SCAN_ADDR_DISP_EN
        , .hex_addr(hex_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    end

    // Model: cycles since reset release decide clear/tick; RAM is a plain array.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_q;
    int            m_ptr;
    int            m_addr;
    int            m_cyc   = 0;
    int            m_ticks = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc  <= 0;
            m_q    <= '0;
            m_ptr  <= 0;
            m_addr <= 0;
            foreach (m_mem[i]) m_mem[i] <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) > DEPTH && ((m_cyc + 1) % TDIV) == 0) begin
                m_q     <= m_mem[m_ptr];
                m_addr  <= m_ptr;
                if (we) m_mem[wr_addr] <= wr_data;
                m_ptr   <= scan ? (m_ptr + 1) % DEPTH : int'(rd_addr);
                m_ticks <= m_ticks + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   32'(busy),   32'(m_cyc < DEPTH));
            chk("q",      32'(q),      32'(m_q));
            chk("rd_ptr", 32'(rd_ptr), 32'(m_ptr));
            chk("hex",    32'(hex),    32'({seg_tab[m_q[7:4]], seg_tab[m_q[3:0]]}));
`ifdef RAM_SCAN_ADDR_DISP_EN
            chk("hex_addr", 32'(hex_addr), 32'(seg_tab[m_addr[3:0]]));
`endif
        end
    end

    task automatic do_ticks(input int n);
        int target;
        int guard;
        target = m_ticks + n;
        guard  = 0;
        while (m_ticks < target && guard < 20*n + 40) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (m_ticks < target) begin
            bad++;
            $display("FAIL tick_wait: got %0d ticks expected %0d", m_ticks, target);
        end
    endtask

    task automatic measure_clear();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy === 1'b1 && n < 40);
        chk("busy_len", 32'(n), 32'(DEPTH));
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; scan = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_q",   32'(q),   32'h0);
        chk("rst_hex", 32'(hex), 32'(14'b1000000_1000000));
        rst = 1'b0;

        // 1: clear length, then every location reads zero
        measure_clear();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            do_ticks(1);
        end
        do_ticks(1);
        chk("clr_q", 32'(q), 32'h0);

        // 2: write A5 to 3 and read it back manually
        we = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        do_ticks(1);
        we = 1'b0; rd_addr = 4'd3;
        do_ticks(2);
        chk("t2_q",   32'(q),   32'hA5);
        chk("t2_hex", 32'(hex), 32'(14'b0001000_0010010));

        // 3: fill 11..1F,10 then scan through the wrap
        rd_addr = 4'd0;
        for (int a = 0; a < DEPTH; a++) begin
            we = 1'b1; wr_addr = AW'(a); wr_data = 8'h10 | DW'((a + 1) % 16);
            do_ticks(1);
        end
        we = 1'b0; scan = 1'b1;
        do_ticks(16);
        chk("t3_wrap_q",   32'(q),      32'h10);
        chk("t3_wrap_ptr", 32'(rd_ptr), 32'h0);
        do_ticks(2);
        chk("t3_scan_q", 32'(q), 32'h12);
        scan = 1'b0; rd_addr = 4'd7;
        do_ticks(2);
        chk("t3_man_q", 32'(q), 32'h18);

        // 4: same-tick write and read of one address returns old data
        we = 1'b1; wr_addr = 4'd5; wr_data = 8'h99; rd_addr = 4'd5;
        do_ticks(1);
        wr_data = 8'h3C;
        do_ticks(1);
        chk("t4_old", 32'(q), 32'h99);
        we = 1'b0;
        do_ticks(1);
        chk("t4_new", 32'(q), 32'h3C);

        // 6: scan through address 12
        rd_addr = 4'd12;
        do_ticks(1);
        scan = 1'b1;
        do_ticks(1);
        chk("t6_q", 32'(q), 32'h1D);
`ifdef RAM_SCAN_ADDR_DISP_EN
        chk("t6_hex_addr", 32'(hex_addr), 32'(7'b1000110));
`endif

        // 5: reset mid-scan, inputs ignored during clear
        scan = 1'b0; rd_addr = 4'd9;
        do_ticks(1);
        scan = 1'b1;
        do_ticks(1);
        chk("t5_pre_q", 32'(q), 32'h1A);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_q",    32'(q),      32'h0);
        chk("t5_rst_ptr",  32'(rd_ptr), 32'h0);
        chk("t5_rst_busy", 32'(busy),   32'h1);
        @(negedge clk);
        rst = 1'b0; we = 1'b1; wr_addr = 4'd2; wr_data = 8'hFF; rd_addr = 4'd4;
        measure_clear();
        chk("t5_ptr_hold", 32'(rd_ptr), 32'h0);
        we = 1'b0; scan = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            do_ticks(1);
            if (a == 3) chk("t5_addr2_q", 32'(q), 32'h0);
        end
        do_ticks(1);
        chk("t5_end_q", 32'(q), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
